mac_seq_ctrl: RTL and testbench

- Sequencer that owns one 16x16 unsigned combinational multiplier and runs a vector multiply-accumulate of programmable length.
- Accepts operand pairs over a valid/ready stream, drives the multiplier from registered operands, registers each product and accumulates it.
- Presents the final sum over a valid/ready result port.
- Sits between the operand source (buffer or host interface) and the shared multiplier instance.

---
 rtl/mac_seq_if.sv | 18 +
 rtl/mac_seq_ctrl.sv | 67 ++++++
 tb/tb_mac_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_if.sv
// mac_seq_if: operand stream, control and result port of the MAC sequencer.
interface mac_seq_if #(parameter int ACC_W = 40, parameter int CNT_W = 8);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic             busy;
  modport master (output start, len, in_valid, in_a, in_b, out_ready,
                  input in_ready, out_valid, acc_out, overflow, busy);
  modport slave (input start, len, in_valid, in_a, in_b, out_ready,
                 output in_ready, out_valid, acc_out, overflow, busy);
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: vector multiply-accumulate sequencer driving a shared 16x16 multiplier.
module mac_seq_ctrl #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mac_seq_if.slave    s,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] rem;
  logic v1, v2, ovf, hs, go;
  logic [31:0] prod;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  assign hs = s.in_valid & s.in_ready;
  assign go = state == IDLE && s.start;
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod);
  assign s.in_ready = state == LOAD;
  assign s.out_valid = state == DONE;
  assign s.busy = state != IDLE;
  assign s.acc_out = acc;
  assign s.overflow = ovf;
  // The last product is still in flight while v2 is set and nothing follows it.
  always_comb begin
    nxt = state;
    if (go) nxt = s.len == '0 ? DONE : LOAD;
    if (state == LOAD && hs && rem == CNT_W'(1)) nxt = DRAIN;
    if (state == DRAIN && v2 && !v1) nxt = DONE;
    if (state == DONE && s.out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      rem <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      prod <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      v1 <= hs;
      v2 <= v1;
      if (hs) begin
        mul_a <= s.in_a;
        mul_b <= s.in_b;
        rem <= rem - CNT_W'(1);
      end
      if (v1) prod <= mul_p;
      if (go) begin
        acc <= '0;
        ovf <= 1'b0;
        rem <= s.len;
      end else if (v2) begin
        acc <= sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
      end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: scoreboard bench for mac_seq_ctrl, built with a 32-bit accumulator
// so that wrap-around and the overflow flag are reachable with short vectors.
module tb_mac_seq_ctrl;
  localparam int AW = 32;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  int n_chk = 0;
  int n_fail = 0;
  logic [AW:0] sb[$];
  logic [AW:0] exp_r;
  logic [63:0] m_acc;
  bit m_ovf;
  mac_seq_if #(.ACC_W(AW), .CNT_W(CW)) m();
  mac_seq_ctrl #(.ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s(m), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p));
  assign mul_p = {16'b0, mul_a} * {16'b0, mul_b};
  always #5 clk = ~clk;

  task automatic do_start(input logic [CW-1:0] l);
    m.start = 1'b1;
    m.len = l;
    m_acc = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    m.start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, output bit to);
    logic [63:0] s;
    int n = 0;
    m.in_valid = 1'b1;
    m.in_a = a;
    m.in_b = b;
    while (!m.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    to = !m.in_ready;
    @(negedge clk);
    m.in_valid = 1'b0;
    s = m_acc + {48'b0, a} * {48'b0, b};
    if ((s >> AW) != 0) m_ovf = 1'b1;
    m_acc = s & ((64'd1 << AW) - 1);
  endtask

  task automatic push_exp();
    sb.push_back({m_ovf, m_acc[AW-1:0]});
  endtask

  task automatic wait_valid(output bit to);
    int n = 0;
    while (!m.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    to = !m.out_valid;
  endtask

  task automatic pop_exp();
    exp_r = sb.size() != 0 ? sb.pop_front() : {1'b1, {AW{1'b1}}};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({m.in_ready, m.out_valid, m.busy, m.overflow} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {m.in_ready, m.out_valid, m.busy, m.overflow});
    end
    n_chk++;
    if ({m.acc_out, mul_a, mul_b} !== '0) begin
      n_fail++; $display("FAIL reset_data got acc=%h a=%h b=%h exp 0", m.acc_out, mul_a, mul_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to, t2;
    m.out_ready = 1'b1;
    do_start(3);
    send(16'd2, 16'd3, to);
    send(16'd4, 16'd5, t2);
    to |= t2;
    send(16'hFFFF, 16'hFFFF, t2);
    to |= t2;
    push_exp();
    n_chk++;
    if (to) begin n_fail++; $display("FAIL basic_handshake got timeout exp accepted"); end
    n_chk++;
    if (m.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early1 got %b exp 0", m.out_valid); end
    @(negedge clk);
    n_chk++;
    if (m.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early2 got %b exp 0", m.out_valid); end
    @(negedge clk);
    n_chk++;
    if (m.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", m.out_valid); end
    pop_exp();
    n_chk++;
    if ({m.overflow, m.acc_out} !== exp_r) begin
      n_fail++; $display("FAIL basic_acc got %h exp %h", {m.overflow, m.acc_out}, exp_r);
    end
    n_chk++;
    if (m.acc_out !== 32'hFFFE001B) begin n_fail++; $display("FAIL basic_const got %h exp fffe001b", m.acc_out); end
    @(negedge clk);
    n_chk++;
    if (m.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b exp 0", m.busy); end
  endtask

  task automatic test_bubbles();
    bit to, t2;
    logic [AW-1:0] held;
    m.out_ready = 1'b0;
    do_start(2);
    send(16'd7, 16'd9, to);
    repeat (3) @(negedge clk);
    send(16'd100, 16'd3, t2);
    push_exp();
    wait_valid(t2);
    to |= t2;
    n_chk++;
    if (to) begin n_fail++; $display("FAIL bubbles_timeout got timeout exp result"); end
    held = m.acc_out;
    pop_exp();
    n_chk++;
    if ({m.overflow, m.acc_out} !== exp_r) begin
      n_fail++; $display("FAIL bubbles_acc got %h exp %h", {m.overflow, m.acc_out}, exp_r);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({m.out_valid, m.acc_out} !== {1'b1, held}) begin
        n_fail++; $display("FAIL bubbles_hold got v=%b acc=%h exp v=1 acc=%h", m.out_valid, m.acc_out, held);
      end
    end
    m.out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({m.busy, m.out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL bubbles_idle got busy=%b v=%b exp 0 0", m.busy, m.out_valid);
    end
  endtask

  task automatic test_overflow();
    bit to, t2;
    m.out_ready = 1'b1;
    do_start(2);
    send(16'hFFFF, 16'hFFFF, to);
    send(16'hFFFF, 16'hFFFF, t2);
    push_exp();
    wait_valid(t2);
    pop_exp();
    n_chk++;
    if (to || {m.overflow, m.acc_out} !== exp_r || exp_r !== {1'b1, 32'hFFFC0002}) begin
      n_fail++; $display("FAIL ovf_set got %h exp %h", {m.overflow, m.acc_out}, {1'b1, 32'hFFFC0002});
    end
    @(negedge clk);
    do_start(1);
    send(16'd1, 16'd1, to);
    push_exp();
    wait_valid(t2);
    pop_exp();
    n_chk++;
    if (to || t2 || {m.overflow, m.acc_out} !== exp_r) begin
      n_fail++; $display("FAIL ovf_clear got %h exp %h", {m.overflow, m.acc_out}, exp_r);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    m.out_ready = 1'b0;
    do_start(0);
    push_exp();
    m.in_valid = 1'b1;
    pop_exp();
    n_chk++;
    if ({m.out_valid, m.overflow, m.acc_out} !== {1'b1, exp_r}) begin
      n_fail++; $display("FAIL zero_result got v=%b %h exp v=1 %h", m.out_valid, {m.overflow, m.acc_out}, exp_r);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (m.in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready got %b exp 0", m.in_ready); end
    end
    m.in_valid = 1'b0;
    m.out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (m.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b exp 0", m.busy); end
  endtask

  task automatic test_ignored();
    bit to, t2;
    m.out_ready = 1'b1;
    do_start(2);
    send(16'd3, 16'd3, to);
    m.start = 1'b1;
    m.len = 8'd5;
    send(16'd4, 16'd4, t2);
    m.start = 1'b0;
    to |= t2;
    push_exp();
    m.in_valid = 1'b1;
    wait_valid(t2);
    pop_exp();
    n_chk++;
    if (to || t2 || {m.overflow, m.acc_out} !== exp_r) begin
      n_fail++; $display("FAIL ignored_acc got %h exp %h", {m.overflow, m.acc_out}, exp_r);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({m.in_ready, m.busy} !== 2'b00) begin
        n_fail++; $display("FAIL ignored_idle got rdy=%b busy=%b exp 0 0", m.in_ready, m.busy);
      end
    end
    m.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit to, t2;
    m.out_ready = 1'b1;
    do_start(4);
    send(16'd1, 16'd2, to);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({m.in_ready, m.out_valid, m.busy, m.overflow, m.acc_out, mul_a, mul_b} !== '0) begin
      n_fail++; $display("FAIL rstmid got rdy=%b v=%b busy=%b acc=%h a=%h exp all 0",
                         m.in_ready, m.out_valid, m.busy, m.acc_out, mul_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(1);
    send(16'd6, 16'd7, t2);
    push_exp();
    wait_valid(t2);
    pop_exp();
    n_chk++;
    if (to || t2 || {m.overflow, m.acc_out} !== exp_r || m.acc_out !== 32'd42) begin
      n_fail++; $display("FAIL rstmid_acc got %h exp %h", {m.overflow, m.acc_out}, exp_r);
    end
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_empty got %0d exp 0", sb.size()); end
  endtask

  initial begin
    m.start = 1'b0;
    m.len = '0;
    m.in_valid = 1'b0;
    m.in_a = '0;
    m.in_b = '0;
    m.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_overflow();
    test_zero_len();
    test_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
